// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and helpers for the internal data-bus arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, GRANT, TURN)
//   MAX_NREQ       : largest supported requester count
//   idx_w()        : width of a binary requester index for n requesters
//   onehot_to_idx(): binary index of the set bit in a one-hot (or zero) vector
// ---------------------------------------------------------------------------
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int MAX_NREQ = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR-reduction of the indices of set bits; exact for one-hot input,
  // zero for an all-zero vector.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin select: the first candidate at or after ptr,
// wrapping modulo NREQ. Candidates are req bits not masked by excl.
// Ports:
//   req     in  [NREQ-1:0]  request vector
//   ptr     in  [IDW-1:0]   highest-priority index (must be < NREQ)
//   excl    in  [NREQ-1:0]  requesters removed from this selection
//   win_oh  out [NREQ-1:0]  one-hot winner, zero when nothing found
//   win_idx out [IDW-1:0]   binary index of the winner, zero when nothing found
//   found   out             a winner exists
// ---------------------------------------------------------------------------
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [idx_w(NREQ)-1:0]  ptr,
  input  logic [NREQ-1:0]         excl,
  output logic [NREQ-1:0]         win_oh,
  output logic [idx_w(NREQ)-1:0]  win_idx,
  output logic                    found
);

  localparam int IDW = idx_w(NREQ);

  logic [NREQ-1:0]   cand;
  logic [2*NREQ-1:0] cand_dbl;
  logic [NREQ-1:0]   cand_rot;
  logic [NREQ-1:0]   win_rot;
  logic [2*NREQ-1:0] win_dbl;

  // Rotate candidates right by ptr so the priority position lands on bit 0,
  // isolate the lowest set bit, then rotate the winner back left by ptr.
  always_comb begin
    cand     = req & ~excl;
    cand_dbl = {cand, cand} >> ptr;
    cand_rot = cand_dbl[NREQ-1:0];
    win_rot  = cand_rot & (~cand_rot + NREQ'(1));
    win_dbl  = {win_rot, win_rot} << ptr;
    win_oh   = win_dbl[2*NREQ-1:NREQ];
    found    = |cand;
  end

  assign win_idx = IDW'(onehot_to_idx(MAX_NREQ'(win_oh)));

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the CPU internal tristate data bus. Grants are
// one-hot and registered so they can drive out_enable of the bus drivers
// directly; TURNAROUND dead cycles separate different owners.
// Optional feature macro: BUS_ARB_TIMEOUT_EN -- forced release of an unlocked
// owner after MAX_HOLD grant cycles when another requester is waiting.
// Ports:
//   clk        in               rising-edge clock
//   reset      in               synchronous, active-high reset
//   req        in  [NREQ-1:0]   level-sensitive bus requests
//   lock       in  [NREQ-1:0]   owner keeps the bus while its lock bit is high
//   gnt        out [NREQ-1:0]   one-hot grant (tristate out_enable)
//   gnt_id     out [IDW-1:0]    binary owner index, 0 when no grant
//   gnt_valid  out              any grant active
//   turnaround out              bus dead cycle
//   timeout    out              one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  output logic [NREQ-1:0]         gnt,
  output logic [idx_w(NREQ)-1:0]  gnt_id,
  output logic                    gnt_valid,
  output logic                    turnaround,
  output logic                    timeout
);

  localparam int IDW = idx_w(NREQ);
  localparam int TCW = 2;
  localparam logic [TCW-1:0] TURN_LOAD = TCW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  if (NREQ < 2 || NREQ > MAX_NREQ || TURNAROUND < 0 || TURNAROUND > 3 ||
      MAX_HOLD < 1) begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            turnaround_q, turnaround_d;
  logic [TCW-1:0]  tcnt_q, tcnt_d;

  logic [NREQ-1:0] excl;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;
  logic            found;
  logic            own_hold;
  logic            force_rel;
  logic            release_own;
  logic            do_grant;
  logic            do_idle;

  // Only a releasing owner is excluded; after a dead cycle the previous owner
  // competes again, already last in line because ptr sits just past it.
  assign excl = (state_q == GRANT) ? gnt_q : '0;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .excl    (excl),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .found   (found)
  );

  assign own_hold = |(gnt_q & (req | lock));

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);

  logic [HCW-1:0] hold_q, hold_d;
  logic           timeout_q, timeout_d;
  logic           others_pending;
  logic           owner_locked;

  assign others_pending = |(req & ~gnt_q);
  assign owner_locked   = |(gnt_q & lock);
  // A natural release takes precedence, so the pulse marks only releases
  // that the owner did not ask for.
  assign force_rel      = own_hold && (hold_q >= HOLD_MAX) && others_pending && !owner_locked;
`else
  assign force_rel = 1'b0;
`endif

  assign release_own = ~own_hold | force_rel;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    turnaround_d = 1'b0;
    tcnt_d       = tcnt_q;
    do_grant     = 1'b0;
    do_idle      = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d       = hold_q;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (found) do_grant = 1'b1;
        else       do_idle  = 1'b1;
      end

      GRANT: begin
        if (release_own) begin
`ifdef BUS_ARB_TIMEOUT_EN
          timeout_d = force_rel;
          hold_d    = '0;
`endif
          if (TURNAROUND == 0) begin
            if (found) do_grant = 1'b1;
            else       do_idle  = 1'b1;
          end else begin
            state_d      = TURN;
            turnaround_d = 1'b1;
            tcnt_d       = TURN_LOAD;
            gnt_d        = '0;
            gnt_id_d     = '0;
            gnt_valid_d  = 1'b0;
          end
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
          // Saturate so a long uncontested hold releases as soon as
          // another requester shows up.
          if (hold_q != HOLD_MAX) hold_d = hold_q + HCW'(1);
`endif
        end
      end

      TURN: begin
        if (tcnt_q != '0) begin
          tcnt_d       = tcnt_q - TCW'(1);
          turnaround_d = 1'b1;
        end else if (found) begin
          do_grant = 1'b1;
        end else begin
          do_idle = 1'b1;
        end
      end

      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_d     = GRANT;
      gnt_d       = win_oh;
      gnt_id_d    = win_idx;
      gnt_valid_d = 1'b1;
      ptr_d       = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
`ifdef BUS_ARB_TIMEOUT_EN
      hold_d      = HCW'(1);
`endif
    end

    if (do_idle) begin
      state_d     = IDLE;
      gnt_d       = '0;
      gnt_id_d    = '0;
      gnt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      turnaround_q <= 1'b0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      gnt_valid_q  <= gnt_valid_d;
      turnaround_q <= turnaround_d;
      tcnt_q       <= tcnt_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt        = gnt_q;
  assign gnt_id     = gnt_id_q;
  assign gnt_valid  = gnt_valid_q;
  assign turnaround = turnaround_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Two arbiters share one stimulus: u_ta1 (TURNAROUND=1, MAX_HOLD=4) and
// u_ta0 (TURNAROUND=0). Each table row selects which one it checks.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  typedef struct {
    string      name;
    bit         sel;   // 1: check u_ta1, 0: check u_ta0
    bit         rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] gnt;
    bit         tr;
    bit         tmo;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] lock;

  logic [3:0] gnt1, gnt0;
  logic [1:0] id1, id0;
  logic       v1, v0, tr1, tr0, to1, to0;

  int checks;
  int failures;
  bit mon_en;
  logic [3:0] prev1;

  vec_t tab[$];
  vec_t exp_q[$];

  bus_arbiter #(.NREQ(4), .TURNAROUND(1), .MAX_HOLD(4)) u_ta1 (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .gnt(gnt1), .gnt_id(id1), .gnt_valid(v1), .turnaround(tr1), .timeout(to1)
  );

  bus_arbiter #(.NREQ(4), .TURNAROUND(0), .MAX_HOLD(16)) u_ta0 (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0), .turnaround(tr0), .timeout(to0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic void add(input string nm, input bit s, input bit r,
                              input logic [3:0] rq, input logic [3:0] lk,
                              input logic [3:0] g, input bit t, input bit to);
    vec_t v;
    v.name = nm; v.sel = s; v.rst = r; v.req = rq; v.lock = lk;
    v.gnt = g; v.tr = t; v.tmo = to;
    tab.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Per-cycle invariants on both arbiters.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot_ta1", {31'd0, $onehot0(gnt1)}, 32'd1);
      chk("onehot_ta0", {31'd0, $onehot0(gnt0)}, 32'd1);
      chk("valid_ta1", {31'd0, v1}, {31'd0, |gnt1});
      chk("adjacent_owners_ta1",
          {31'd0, (prev1 != 4'd0) && (gnt1 != 4'd0) && (prev1 != gnt1)}, 32'd0);
    end
    prev1 = gnt1;
  end

  initial begin
    vec_t e;
    logic [3:0] g_act;
    logic [1:0] id_act;
    logic       v_act, tr_act, to_act;

    checks = 0; failures = 0; mon_en = 1'b0; prev1 = 4'd0;
    reset = 1'b1; req = 4'd0; lock = 4'd0;

    //   name         sel rst req      lock     gnt      tr tmo
    add("reset0",      1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add("reset1",      1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add("first_gnt",   1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add("rel0",        1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add("to_idle",     1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    // round robin, each owner drops req two cycles after its grant
    add("rr_rst",      1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add("rr_g0",       1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
    add("rr_h0",       1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
    add("rr_t0",       1, 0, 4'b1110, 4'b0000, 4'b0000, 1, 0);
    add("rr_g1",       1, 0, 4'b1111, 4'b0000, 4'b0010, 0, 0);
    add("rr_h1",       1, 0, 4'b1111, 4'b0000, 4'b0010, 0, 0);
    add("rr_t1",       1, 0, 4'b1101, 4'b0000, 4'b0000, 1, 0);
    add("rr_g2",       1, 0, 4'b1111, 4'b0000, 4'b0100, 0, 0);
    add("rr_h2",       1, 0, 4'b1111, 4'b0000, 4'b0100, 0, 0);
    add("rr_t2",       1, 0, 4'b1011, 4'b0000, 4'b0000, 1, 0);
    add("rr_g3",       1, 0, 4'b1111, 4'b0000, 4'b1000, 0, 0);
    add("rr_h3",       1, 0, 4'b1111, 4'b0000, 4'b1000, 0, 0);
    add("rr_t3",       1, 0, 4'b0111, 4'b0000, 4'b0000, 1, 0);
    add("rr_g0_again", 1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
    add("rr_rel",      1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add("rr_idle",     1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    // lock keeps owner 2 while requester 0 waits
    add("lk_g2",       1, 0, 4'b0100, 4'b0000, 4'b0100, 0, 0);
    add("lk_h1",       1, 0, 4'b0101, 4'b0100, 4'b0100, 0, 0);
    add("lk_h2",       1, 0, 4'b0001, 4'b0100, 4'b0100, 0, 0);
    add("lk_h3",       1, 0, 4'b0001, 4'b0100, 4'b0100, 0, 0);
    add("lk_drop",     1, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0);
    add("lk_g0",       1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add("lk_rel",      1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add("lk_idle",     1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add("lock_no_req", 1, 0, 4'b0000, 4'b1111, 4'b0000, 0, 0);
    // reset while owner 3 holds the bus
    add("mr_g3",       1, 0, 4'b1000, 4'b0000, 4'b1000, 0, 0);
    add("mr_reset",    1, 1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add("mr_g0",       1, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0);
    add("mr_rel",      1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add("mr_idle",     1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
`ifdef BUS_ARB_TIMEOUT_EN
    add("to_g0",       1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add("to_h2",       1, 0, 4'b0011, 4'b0000, 4'b0001, 0, 0);
    add("to_h3",       1, 0, 4'b0011, 4'b0000, 4'b0001, 0, 0);
    add("to_h4",       1, 0, 4'b0011, 4'b0000, 4'b0001, 0, 0);
    add("to_force",    1, 0, 4'b0011, 4'b0000, 4'b0000, 1, 1);
    add("to_g1",       1, 0, 4'b0011, 4'b0000, 4'b0010, 0, 0);
    add("to_rel1",     1, 0, 4'b0001, 4'b0000, 4'b0000, 1, 0);
    add("tl_g0",       1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add("tl_h2",       1, 0, 4'b0011, 4'b0001, 4'b0001, 0, 0);
    add("tl_h3",       1, 0, 4'b0011, 4'b0001, 4'b0001, 0, 0);
    add("tl_h4",       1, 0, 4'b0011, 4'b0001, 4'b0001, 0, 0);
    add("tl_h5",       1, 0, 4'b0011, 4'b0001, 4'b0001, 0, 0);
    add("tl_h6",       1, 0, 4'b0011, 4'b0001, 4'b0001, 0, 0);
    add("tl_rel",      1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add("tl_idle",     1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
`else
    add("nt_g0",       1, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    for (int k = 0; k < 6; k++)
      add("nt_hold",   1, 0, 4'b0011, 4'b0000, 4'b0001, 0, 0);
    add("nt_rel0",     1, 0, 4'b0010, 4'b0000, 4'b0000, 1, 0);
    add("nt_g1",       1, 0, 4'b0010, 4'b0000, 4'b0010, 0, 0);
    add("nt_rel1",     1, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    add("nt_idle",     1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
`endif
    // zero-turnaround arbiter: direct hand-over, never two bits set
    add("z_reset",     0, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add("z_g0",        0, 0, 4'b0011, 4'b0000, 4'b0001, 0, 0);
    add("z_g1_direct", 0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 0);
    add("z_h1",        0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 0);
    add("z_idle",      0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add("z_g0_wrap",   0, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add("z_h0",        0, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add("z_same_cyc",  0, 0, 4'b0100, 4'b0000, 4'b0100, 0, 0);
    add("z_end",       0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    mon_en = 1'b1;
    foreach (tab[i]) begin
      reset = tab[i].rst;
      req   = tab[i].req;
      lock  = tab[i].lock;
      exp_q.push_back(tab[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      g_act  = e.sel ? gnt1 : gnt0;
      id_act = e.sel ? id1  : id0;
      v_act  = e.sel ? v1   : v0;
      tr_act = e.sel ? tr1  : tr0;
      to_act = e.sel ? to1  : to0;
      chk($sformatf("%s[%0d].gnt", e.name, i), {28'd0, g_act}, {28'd0, e.gnt});
      chk($sformatf("%s[%0d].gnt_id", e.name, i), {30'd0, id_act}, {30'd0, exp_idx(e.gnt)});
      chk($sformatf("%s[%0d].gnt_valid", e.name, i), {31'd0, v_act}, {31'd0, |e.gnt});
      chk($sformatf("%s[%0d].turnaround", e.name, i), {31'd0, tr_act}, {31'd0, e.tr});
      chk($sformatf("%s[%0d].timeout", e.name, i), {31'd0, to_act}, {31'd0, e.tmo});
    end
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares the CPU internal tristate data bus among NREQ drivers (register buslatches, flaglatch, ALU result, memory input latch).
- Produces one-hot registered grants that connect directly to the drivers' out_enable inputs.
- Inserts programmable dead cycles between different owners so two tristates never drive the bus in the same cycle.
- Sits between the microcode decoder (request/lock source) and the datapath bus drivers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TURNAROUND, 1, idle cycles with no grant between owner changes (0..3).
- MAX_HOLD, 16, maximum cycles an unlocked owner keeps the bus while others wait. Used only with BUS_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  reset, synchronous, active-high.
- req  input  NREQ  per-requester bus request, level-sensitive.
- lock  input  NREQ  per-requester hold; keeps the grant while high, even without req.
- gnt  output  NREQ  one-hot grant; drives tristate out_enable.
- gnt_id  output  $clog2(NREQ)  binary index of the current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  high when any gnt bit is high.
- turnaround  output  1  high during bus dead cycles.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when the macro is undefined.

Behaviour:
- All outputs are registered. Reset values: gnt=0, gnt_id=0, gnt_valid=0, turnaround=0, timeout=0. Internal state: state=IDLE, rr pointer ptr=0, turnaround counter=0, hold counter=0.
- Reset mid-grant: all outputs are 0 after the next edge. ptr returns to 0. Pending requests are re-arbitrated from IDLE.
- States: IDLE, GRANT, TURN.
- IDLE:
  - Arbitrate when any req bit is set. Winner is the first set req bit at or after ptr, wrapping modulo NREQ.
  - Latency: req visible at edge N gives gnt at edge N+1.
  - No req: stay in IDLE.
- GRANT:
  - Owner o keeps the grant while req[o] | lock[o].
  - When both are low, release. If TURNAROUND=0, arbitrate among the other requesters in the same cycle: new gnt on the next edge, or IDLE if there are none. If TURNAROUND>0, go to TURN.
  - req or lock bits of non-owners never affect the current grant (no preemption), except via timeout.
- TURN:
  - gnt=0, turnaround=1 for exactly TURNAROUND cycles.
  - Then arbitrate as in IDLE. Result: GRANT with the new gnt, or IDLE.
  - The previous owner may win again, but at lowest priority.
- Pointer: on each grant to index i, ptr <= (i+1) mod NREQ. With all requesters active, service order is 0,1,…,NREQ-1,0.
- Invariants:
  - gnt is always one-hot or zero.
  - With TURNAROUND>0, two distinct owners are never granted on adjacent cycles.
  - gnt_valid == |gnt.
- Simultaneous events: owner release and new requests in the same cycle are evaluated together. A requester that raises req in a release cycle is eligible.
- lock without prior grant is ignored. lock does not raise priority.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter counts GRANT cycles and clears on each new grant.
  - When the counter reaches MAX_HOLD, another req is pending, and lock[owner]=0: force release (TURN, or direct re-arbitration if TURNAROUND=0).
  - Pulse timeout for one cycle, coincident with gnt dropping.
  - Counter saturates at MAX_HOLD when nothing is pending. Release then happens on the first cycle another req appears.
- Undefined: no counter is instantiated, timeout is a constant 0, and owners hold indefinitely.

Decomposition:
- Package bus_arb_pkg holds:
  - state enum arb_state_t {IDLE, GRANT, TURN};
  - localparam function for index width;
  - onehot-to-index function.
- One sub-module: rr_picker, a combinational round-robin priority select.
  - Inputs: req vector, ptr, exclude mask.
  - Outputs: winner one-hot, winner index, found.

Test Plan:
- Reset, then req=0001 at edge 1 → gnt=0001, gnt_id=0, gnt_valid=1 at edge 2; turnaround=0.
- TURNAROUND=1, req=1111, each owner drops req 2 cycles after grant, then re-raises → grant order 0,1,2,3,0 with exactly one gnt=0/turnaround=1 cycle between owners.
- Owner 2 holds gnt=0100, drops req with lock=0100 while req=0001 pending → gnt stays 0100. When lock drops, one dead cycle follows, then gnt=0001.
- TURNAROUND=0, req=0011, owner 0 drops req → gnt goes 0001 directly to 0010 on the next edge; never 0011.
- BUS_ARB_TIMEOUT_EN, MAX_HOLD=4, req0 held, req1 raised → gnt0 for 4 cycles, timeout pulses once, gnt=0010 after turnaround. Repeat with lock0=1 → no timeout, gnt0 retained.
- Reset asserted while gnt=1000 → all outputs 0 at next edge. With req=1111 held after reset release, first grant is 0001 (ptr=0).
